// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port: one registered grant per cycle,
// one-hot register write enable, shared write data, and register 0 kept read-only.
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REGS-1:0]            reg_write_enable,
    output logic [DATA_WIDTH-1:0]          reg_d,
    output logic                           busy,
    output logic                           err,
    output logic                           dbg_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        cand;
    logic [PTR_W-1:0]        win;
    logic                    found;
    logic [NUM_REQ-1:0]      eligible;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_data;
    logic [NUM_REQ-1:0]      grant_d;
    logic [NUM_REGS-1:0]     we_d;
    logic [DATA_WIDTH-1:0]   reg_d_d;
    logic                    busy_d;
    logic                    err_d;

    assign dbg_state = state_q;

    // The requester granted this cycle still holds req high, so it sits out one round.
    always_comb begin
        eligible = req & ~grant;
        found    = 1'b0;
        win      = ptr_q;
        cand     = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(win) == i) begin
                win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = IDLE;
        ptr_d   = ptr_q;
        grant_d = '0;
        we_d    = '0;
        reg_d_d = reg_d;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        if (found) begin
            state_d       = GRANT;
            ptr_d         = win;
            grant_d[win]  = 1'b1;
            busy_d        = 1'b1;
            reg_d_d       = win_data;
            // Address 0 is consumed silently; out-of-range addresses are flagged instead.
            if (int'(win_addr) >= NUM_REGS) begin
                err_d = 1'b1;
            end else if (win_addr != '0) begin
                we_d[win_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            ptr_q            <= PTR_W'(NUM_REQ - 1);
            grant            <= '0;
            reg_write_enable <= '0;
            reg_d            <= '0;
            busy             <= 1'b0;
            err              <= 1'b0;
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            grant            <= grant_d;
            reg_write_enable <= we_d;
            reg_d            <= reg_d_d;
            busy             <= busy_d;
            err              <= err_d;
        end
    end

endmodule
